// File: rtl/pyramid_pkg.sv
// Shared types and constants for the pyramid counter and its downstream monitor.
package pyramid_pkg;

   localparam int PM_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ROW_END,
      ERROR
   } pm_state_t;

   localparam logic [1:0] PM_ERR_NONE  = 2'd0;
   localparam logic [1:0] PM_ERR_STEP  = 2'd1;
   localparam logic [1:0] PM_ERR_NOROW = 2'd2;
   localparam logic [1:0] PM_ERR_SPUR  = 2'd3;

endpackage

// File: rtl/level_change_det.sv
// Row-event detector: a strobe in any enabled cycle where the sampled level differs
// from the level seen at the previous enabled sample.
module level_change_det (
   input  logic up,
   input  logic reset,
   input  logic enable,
   input  logic level,
   output logic change
);

   logic prev_row_reg;

   always_ff @(posedge up) begin
      if (reset) begin
         prev_row_reg <= 1'b0;
      end else if (enable) begin
         prev_row_reg <= level;
      end
   end

   assign change = enable & (level ^ prev_row_reg);

endmodule

// File: rtl/pyramid_monitor.sv
// Sequence checker and pyramid statistics for the pyramid counter.
// Define PYRAMID_MONITOR_STICKY_ERR_EN to make the error state terminal until reset.
module pyramid_monitor
   import pyramid_pkg::*;
#(
   parameter int CNT_W = PM_CNT_W,
   parameter int TOT_W = 16
) (
   input  logic             up,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             row_pulse,
   input  logic             done_pulse,
   output logic [CNT_W-1:0] row_idx,
   output logic [CNT_W-1:0] row_limit,
   output logic [TOT_W-1:0] pyr_cnt,
   output logic             done,
   output logic             busy,
   output logic             err,
   output logic [1:0]       err_code
);

   pm_state_t        state_reg, state_next;
   logic [CNT_W-1:0] prev_cnt_reg;
   logic [CNT_W-1:0] row_idx_reg, row_idx_next;
   logic [CNT_W-1:0] row_limit_reg, row_limit_next;
   logic [TOT_W-1:0] pyr_cnt_reg, pyr_cnt_next;
   logic             done_reg, done_next;
   logic             busy_reg, busy_next;
   logic             err_reg, err_next;
   logic [1:0]       err_code_reg, err_code_next;
   logic [1:0]       cause;
   logic             row_evt;
   logic             step_ok;
   logic             wrap_ok;
   logic [CNT_W-1:0] cnt_inc;

   level_change_det u_row_det (
      .up     (up),
      .reset  (reset),
      .enable (enable),
      .level  (row_pulse),
      .change (row_evt)
   );

   // The all-ones to zero wrap is never an ordinary step; only wrap_ok accepts it.
   assign cnt_inc = prev_cnt_reg + 1'b1;
   assign step_ok = (cnt_in == cnt_inc) && (prev_cnt_reg < row_limit_reg);
   assign wrap_ok = (cnt_in == '0) && (prev_cnt_reg == row_limit_reg);

   always_comb begin
      state_next     = state_reg;
      row_idx_next   = row_idx_reg;
      row_limit_next = row_limit_reg;
      pyr_cnt_next   = pyr_cnt_reg;
      done_next      = 1'b0;
`ifdef PYRAMID_MONITOR_STICKY_ERR_EN
      err_next       = err_reg;
`else
      err_next       = 1'b0;
`endif
      err_code_next  = err_code_reg;
      cause          = PM_ERR_NONE;

      if (enable) begin
         case (state_reg)
            IDLE: begin
               if (cnt_in == '0) begin
                  state_next = RUN;
               end
            end
            RUN: begin
               if (wrap_ok && row_evt) begin
                  state_next = ROW_END;
               end else if (wrap_ok) begin
                  cause = PM_ERR_NOROW;
               end else if (row_evt || done_pulse) begin
                  cause = PM_ERR_SPUR;
               end else if (!step_ok) begin
                  cause = PM_ERR_STEP;
               end
            end
            ROW_END: begin
               if (row_evt) begin
                  cause = PM_ERR_SPUR;
               end else if (!step_ok) begin
                  cause = PM_ERR_STEP;
               end else begin
                  state_next = RUN;
                  if ((row_limit_reg == CNT_W'(1)) || done_pulse) begin
                     if (pyr_cnt_reg != '1) begin
                        pyr_cnt_next = pyr_cnt_reg + 1'b1;
                     end
                     done_next      = 1'b1;
                     row_idx_next   = '0;
                     row_limit_next = '1;
                  end else begin
                     row_idx_next   = row_idx_reg + 1'b1;
                     row_limit_next = row_limit_reg - 1'b1;
                  end
               end
            end
            ERROR: begin
`ifdef PYRAMID_MONITOR_STICKY_ERR_EN
               state_next = ERROR;
`else
               state_next     = IDLE;
               row_idx_next   = '0;
               row_limit_next = '1;
`endif
            end
            default: begin
               state_next = IDLE;
            end
         endcase

         if (cause != PM_ERR_NONE) begin
            state_next    = ERROR;
            err_next      = 1'b1;
            err_code_next = cause;
         end
      end

      busy_next = (state_next == RUN) || (state_next == ROW_END);
   end

   always_ff @(posedge up) begin
      if (reset) begin
         state_reg     <= IDLE;
         prev_cnt_reg  <= '0;
         row_idx_reg   <= '0;
         row_limit_reg <= '1;
         pyr_cnt_reg   <= '0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         err_reg       <= 1'b0;
         err_code_reg  <= PM_ERR_NONE;
      end else begin
         state_reg     <= state_next;
         if (enable) begin
            prev_cnt_reg <= cnt_in;
         end
         row_idx_reg   <= row_idx_next;
         row_limit_reg <= row_limit_next;
         pyr_cnt_reg   <= pyr_cnt_next;
         done_reg      <= done_next;
         busy_reg      <= busy_next;
         err_reg       <= err_next;
         err_code_reg  <= err_code_next;
      end
   end

   assign row_idx   = row_idx_reg;
   assign row_limit = row_limit_reg;
   assign pyr_cnt   = pyr_cnt_reg;
   assign done      = done_reg;
   assign busy      = busy_reg;
   assign err       = err_reg;
   assign err_code  = err_code_reg;

endmodule
